// File: rtl/parport_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : parport_pkg
//  Purpose  : Shared constants for the parport_gpio Avalon-MM GPIO block:
//             bus width and the register word-address map.
//  Revision : 1.0  initial release
// ============================================================================
package parport_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PIN     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PORT    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_SET     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_CLR     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd7;

endpackage
`default_nettype wire

// File: rtl/parport_sync.sv
`default_nettype none
// ============================================================================
//  Module   : parport_sync
//  Purpose  : Input synchroniser for the GPIO pins. A SYNC_STAGES-deep flop
//             chain feeds one history flop; rise/fall are derived from the
//             pair and held low during a post-reset warm-up window while the
//             chain fills.
//  Ports    : clk, reset        - clock, async active-high reset
//             pin_i      [W]    - raw pin values (asynchronous)
//             pin_sync_o [W]    - synchronised pin values
//             rise_o     [W]    - rising edge strobe (warm-up gated)
//             fall_o     [W]    - falling edge strobe (warm-up gated)
//  Revision : 1.0  initial release
// ============================================================================
module parport_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] pin_sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int               CNT_W     = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] chain_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;
    logic [CNT_W-1:0] warm_cnt_q;
    logic [CNT_W-1:0] warm_cnt_d;
    logic             warm_done;

    // Saturating counter: edges are only trusted once the chain and the
    // history flop both hold post-reset samples, so a pin held high through
    // reset never looks like a rising edge.
    always_comb begin
        warm_cnt_d = warm_cnt_q;
        if (warm_cnt_q != WARM_DONE) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= '0;
            end
            hist_q     <= '0;
            warm_cnt_q <= '0;
        end else begin
            chain_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            hist_q     <= chain_q[SYNC_STAGES-1];
            warm_cnt_q <= warm_cnt_d;
        end
    end

    assign warm_done  = (warm_cnt_q == WARM_DONE);
    assign pin_sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o     = warm_done ? ( pin_sync_o & ~hist_q) : '0;
    assign fall_o     = warm_done ? (~pin_sync_o &  hist_q) : '0;

endmodule
`default_nettype wire

// File: rtl/parport_gpio.sv
`default_nettype none
// ============================================================================
//  Module   : parport_gpio
//  Purpose  : Avalon-MM slave GPIO with WIDTH tri-state pins: per-pin
//             direction, atomic set/clear, synchronised pin readback, and
//             per-pin rising/falling edge capture with a level interrupt.
//  Ports    : clk, reset           - clock, async active-high reset
//             address[3]           - register word address
//             chipselect           - slave select
//             write, writedata[32] - write strobe and data
//             read                 - read strobe
//             readdata[32]         - registered read data (1-cycle latency)
//             irq                  - level interrupt, |EDGE registered
//             ParPort[WIDTH]       - bidirectional pins
//  Revision : 1.0  initial release
// ============================================================================
module parport_gpio
    import parport_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_DIR   = 32'h0,
    parameter logic [31:0] RESET_PORT  = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  ParPort
);

    logic [WIDTH-1:0]  dir_q,     dir_d;
    logic [WIDTH-1:0]  port_q,    port_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [WIDTH-1:0]  edge_q,    edge_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q,     irq_d;

    logic              wr_en;
    logic              rd_en;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  w1c_mask;
    logic [WIDTH-1:0]  edge_set;
    logic [WIDTH-1:0]  rd_word;
    logic [DATA_W-1:0] rd_ext;

    logic [WIDTH-1:0]  pin_sync;
    logic [WIDTH-1:0]  pin_rise;
    logic [WIDTH-1:0]  pin_fall;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;
    assign wdata = writedata[WIDTH-1:0];

    // Output pins are sampled too, so PIN reflects the driven value.
    parport_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .pin_i      (ParPort),
        .pin_sync_o (pin_sync),
        .rise_o     (pin_rise),
        .fall_o     (pin_fall)
    );

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            assign ParPort[gi] = dir_q[gi] ? port_q[gi] : 1'bz;
        end
    endgenerate

    assign edge_set = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

    // Register writes and edge capture.
    always_comb begin
        dir_d     = dir_q;
        port_d    = port_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        if (wr_en) begin
            case (address)
                ADDR_DIR:     dir_d     = wdata;
                ADDR_PORT:    port_d    = wdata;
                ADDR_SET:     port_d    = port_q | wdata;
                ADDR_CLR:     port_d    = port_q & ~wdata;
                ADDR_RISE_EN: rise_en_d = wdata;
                ADDR_FALL_EN: fall_en_d = wdata;
                ADDR_EDGE:    w1c_mask  = wdata;
                default:      ;
            endcase
        end
        // A new edge in the same cycle as its W1C survives.
        edge_d = (edge_q & ~w1c_mask) | edge_set;
        irq_d  = |edge_q;
    end

    // Read mux samples the pre-write register state.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DIR:     rd_word = dir_q;
            ADDR_PIN:     rd_word = pin_sync;
            ADDR_PORT:    rd_word = port_q;
            ADDR_RISE_EN: rd_word = rise_en_q;
            ADDR_FALL_EN: rd_word = fall_en_q;
            ADDR_EDGE:    rd_word = edge_q;
            default:      rd_word = '0;
        endcase
        rd_ext                = '0;
        rd_ext[WIDTH-1:0]     = rd_word;
        readdata_d            = rd_en ? rd_ext : readdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q      <= RESET_DIR[WIDTH-1:0];
            port_q     <= RESET_PORT[WIDTH-1:0];
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            port_q     <= port_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_parport_gpio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parport_gpio
//  Purpose  : Self-checking bench for parport_gpio. Instance A: WIDTH=8,
//             SYNC_STAGES=2, RESET_DIR=0xF, RESET_PORT=0x5. Instance B:
//             WIDTH=4, SYNC_STAGES=3 for the glitch case. Read expectations
//             are queued when the read is issued and compared when readdata
//             becomes valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parport_gpio;

    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_PIN  = 3'd1;
    localparam logic [2:0] A_PORT = 3'd2;
    localparam logic [2:0] A_SET  = 3'd3;
    localparam logic [2:0] A_CLR  = 3'd4;
    localparam logic [2:0] A_RISE = 3'd5;
    localparam logic [2:0] A_FALL = 3'd6;
    localparam logic [2:0] A_EDGE = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        cs_a, cs_b;
    logic        write, read;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    logic [7:0]  a_en, a_val;
    logic [3:0]  b_val;
    wire  [7:0]  pa;
    wire  [3:0]  pb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          sel;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pa_drv
            assign pa[gi] = a_en[gi] ? a_val[gi] : 1'bz;
        end
    endgenerate
    assign pb = b_val;

    parport_gpio #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .RESET_DIR   (32'h0000000F),
        .RESET_PORT  (32'h00000005)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs_a),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (rd_a),
        .irq        (irq_a),
        .ParPort    (pa)
    );

    parport_gpio #(
        .WIDTH       (4),
        .SYNC_STAGES (3),
        .RESET_DIR   (32'h0),
        .RESET_PORT  (32'h0)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs_b),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (rd_b),
        .irq        (irq_b),
        .ParPort    (pb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        if (sel) cs_b = 1'b1; else cs_a = 1'b1;
        write     = 1'b1;
        address   = a;
        writedata = d;
        @(negedge clk);
        cs_a  = 1'b0;
        cs_b  = 1'b0;
        write = 1'b0;
    endtask

    task automatic pop_cmp();
        exp_t item;
        item = sb.pop_front();
        chk(item.tag, item.sel ? rd_b : rd_a, item.exp);
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, input logic [31:0] e, input string tag);
        if (sel) cs_b = 1'b1; else cs_a = 1'b1;
        read    = 1'b1;
        address = a;
        sb.push_back('{tag: tag, exp: e, sel: sel});
        @(negedge clk);
        cs_a = 1'b0;
        cs_b = 1'b0;
        read = 1'b0;
        pop_cmp();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        address   = '0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        writedata = '0;
        a_en      = 8'hF0;
        a_val     = 8'h20;   // pin5 held high through reset
        b_val     = 4'h0;

        // ---------------- reset state ----------------
        cyc(3);
        chk("rst_pins", {28'h0, pa[3:0]}, 32'h5);
        chk("rst_irq", {31'h0, irq_a}, 32'h0);
        chk("rst_rdata", rd_a, 32'h0);
        reset = 1'b0;

        // Rising enable on pin5 right after reset: no false edge.
        wr(0, A_RISE, 32'h20);
        cyc(6);
        rd(0, A_EDGE, 32'h0, "no_false_edge");
        chk("no_false_irq", {31'h0, irq_a}, 32'h0);
        rd(0, A_DIR,  32'h0F, "rst_dir");
        rd(0, A_PORT, 32'h05, "rst_port");
        rd(0, A_PIN,  32'h25, "rst_pin");
        rd(0, A_FALL, 32'h00, "rst_fall_en");
        rd(0, A_RISE, 32'h20, "rise_en_rb");

        // Real 1->0->1 on pin5 is captured.
        a_val[5] = 1'b0;
        cyc(3);
        a_val[5] = 1'b1;
        cyc(5);
        rd(0, A_EDGE, 32'h20, "pin5_edge");
        chk("pin5_irq", {31'h0, irq_a}, 32'h1);
        wr(0, A_EDGE, 32'h20);
        wr(0, A_RISE, 32'h0);
        cyc(2);
        rd(0, A_EDGE, 32'h0, "pin5_w1c");
        chk("pin5_irq_clr", {31'h0, irq_a}, 32'h0);

        // ---------------- direction / set / clear ----------------
        a_en = 8'h00;
        wr(0, A_DIR,  32'hFFFF_FFFF);
        wr(0, A_PORT, 32'h0F);
        wr(0, A_SET,  32'hF0);
        wr(0, A_CLR,  32'h03);
        rd(0, A_PORT, 32'hFC, "port_setclr");
        chk("pins_fc", {24'h0, pa}, 32'hFC);
        cyc(2);
        chk("rdata_hold", rd_a, 32'hFC);
        rd(0, A_DIR, 32'hFF, "dir_masked");
        rd(0, A_SET, 32'h0, "set_reads0");
        rd(0, A_CLR, 32'h0, "clr_reads0");
        rd(0, A_PIN, 32'hFC, "pin_driven");

        // Simultaneous read and write returns the pre-write value.
        cs_a = 1'b1; read = 1'b1; write = 1'b1;
        address = A_PORT; writedata = 32'h33;
        sb.push_back('{tag: "rd_wr_same", exp: 32'hFC, sel: 1'b0});
        @(negedge clk);
        cs_a = 1'b0; read = 1'b0; write = 1'b0;
        pop_cmp();
        rd(0, A_PORT, 32'h33, "port_after_rw");

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        reset = 1'b1;
        a_en  = 8'hF0;
        a_val = 8'h00;
        #1;
        chk("async_rst_pins", {28'h0, pa[3:0]}, 32'h5);
        chk("async_rst_rdata", rd_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        wr(0, A_DIR, 32'h0);
        a_en = 8'hFF;
        cyc(6);

        // ---------------- pin0 rise: latency and irq ----------------
        wr(0, A_RISE, 32'h1);
        a_val[0] = 1'b1;
        rd(0, A_PIN, 32'h0, "pin_lat0");
        rd(0, A_PIN, 32'h0, "pin_lat1");
        rd(0, A_PIN, 32'h1, "pin_lat2");
        chk("irq_before", {31'h0, irq_a}, 32'h0);
        rd(0, A_EDGE, 32'h1, "edge0_set");
        chk("irq_after", {31'h0, irq_a}, 32'h1);
        wr(0, A_EDGE, 32'h1);
        chk("irq_lag", {31'h0, irq_a}, 32'h1);
        cyc(1);
        chk("irq_clr", {31'h0, irq_a}, 32'h0);
        rd(0, A_EDGE, 32'h0, "edge0_w1c");
        wr(0, A_RISE, 32'h0);

        // ---------------- fall edge vs same-cycle W1C ----------------
        a_val[1] = 1'b1;
        wr(0, A_FALL, 32'h2);
        cyc(4);
        a_val[1] = 1'b0;
        cyc(2);
        wr(0, A_EDGE, 32'h2);   // lands on the capture edge
        rd(0, A_EDGE, 32'h2, "set_wins");
        wr(0, A_EDGE, 32'h2);
        rd(0, A_EDGE, 32'h0, "fall_w1c");
        wr(0, A_FALL, 32'h0);

        // ---------------- one-cycle glitch, SYNC_STAGES=3 ----------------
        wr(1, A_RISE, 32'h1);
        cyc(2);
        b_val[0] = 1'b1;
        cyc(1);
        b_val[0] = 1'b0;
        cyc(8);
        chk("glitch_irq", {31'h0, irq_b}, 32'h1);
        rd(1, A_EDGE, 32'h1, "glitch_edge");
        wr(1, A_EDGE, 32'h1);
        cyc(4);
        rd(1, A_EDGE, 32'h0, "glitch_once");
        chk("glitch_irq_clr", {31'h0, irq_b}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
